// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {DRAIN, IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic {REQ_I, REQ_D} req_t;

  function automatic int word_bits(input int blocksize);
    return $clog2(blocksize);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-input round-robin picker
// On a tie the side that did not win last time is granted.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  req_t last_grant,
  output logic grant_valid,
  output req_t grant
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant       = REQ_I;
    if (i_req && d_req) begin
      grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req) begin
      grant = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache block-burst arbiter for the shared memory
// Outputs are gated with reset so a burst is abandoned in the cycle reset rises.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLOCKSIZE   = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_req,
  input  logic [31:0]                       i_addr,
  output logic [31:0]                       i_rd,
  output logic                              i_wordvalid,
  output logic                              i_done,
  input  logic                              d_req,
  input  logic                              d_we,
  input  logic [31:0]                       d_addr,
  input  logic [31:0]                       d_wd,
  output logic [31:0]                       d_rd,
  output logic                              d_wordvalid,
  output logic                              d_done,
  output logic [word_bits(BLOCKSIZE)-1:0]   burst_word,
  output logic                              mem_re,
  output logic                              mem_we,
  output logic [31:0]                       mem_a,
  output logic [31:0]                       mem_wd,
  input  logic [31:0]                       mem_rd,
  input  logic                              mem_valid
);

  localparam int WB = word_bits(BLOCKSIZE);
  localparam int DW = $clog2(WAIT_CYCLES + 4);
  localparam logic [WB-1:0] LAST_WORD  = WB'(BLOCKSIZE - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(WAIT_CYCLES + 3);

  state_t        state, state_n;
  logic [DW-1:0] drain_cnt, drain_cnt_n;
  logic [WB-1:0] word_cnt, word_cnt_n;
  req_t          last_grant, last_grant_n;
  logic          grant_valid;
  req_t          grant;
  logic          busy_i, busy_d, busy;
  logic [31:0]   owner_addr;
  logic          last_word;
  logic          unused_addr_bits;

  mem_arb_rr u_rr (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DRAIN;
      drain_cnt  <= DRAIN_LOAD;
      word_cnt   <= '0;
      last_grant <= REQ_I;
    end else begin
      state      <= state_n;
      drain_cnt  <= drain_cnt_n;
      word_cnt   <= word_cnt_n;
      last_grant <= last_grant_n;
    end
  end

  // mem_valid is deliberately ignored outside BUSY so stale completions vanish.
  always_comb begin
    state_n      = state;
    drain_cnt_n  = drain_cnt;
    word_cnt_n   = word_cnt;
    last_grant_n = last_grant;
    case (state)
      DRAIN: begin
        if (drain_cnt == '0) state_n = IDLE;
        else                 drain_cnt_n = drain_cnt - 1'b1;
      end
      IDLE: begin
        if (grant_valid) begin
          state_n      = (grant == REQ_D) ? BUSY_D : BUSY_I;
          last_grant_n = grant;
          word_cnt_n   = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_valid) begin
          word_cnt_n = word_cnt + 1'b1;
          if (word_cnt == LAST_WORD) state_n = IDLE;
        end
      end
      default: state_n = DRAIN;
    endcase
  end

  assign busy_i     = !reset && (state == BUSY_I);
  assign busy_d     = !reset && (state == BUSY_D);
  assign busy       = busy_i | busy_d;
  assign owner_addr = busy_d ? d_addr : i_addr;
  assign last_word  = (word_cnt == LAST_WORD);

  assign mem_a      = busy ? {owner_addr[31:WB+2], word_cnt, 2'b00} : '0;
  assign mem_re     = busy_i | (busy_d & ~d_we);
  assign mem_we     = busy_d & d_we;
  assign mem_wd     = busy ? d_wd : '0;
  assign burst_word = busy ? word_cnt : '0;

  assign i_rd        = busy_i ? mem_rd : '0;
  assign i_wordvalid = busy_i & mem_valid;
  assign i_done      = i_wordvalid & last_word;
  assign d_rd        = busy_d ? mem_rd : '0;
  assign d_wordvalid = busy_d & mem_valid;
  assign d_done      = d_wordvalid & last_word;

  assign unused_addr_bits = ^{i_addr[WB+1:0], d_addr[WB+1:0]};

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequences the shared simulated main memory (single-port, hold-request-until-Valid handshake, configurable wait cycles) between the instruction-cache and data-cache refill/writeback sides. Each grant is a block burst of BLOCKSIZE consecutive words. The arbiter drives the word addresses, steers returned data and per-word valids back to the owner, and signals burst completion. It sits between both caches and mem_simulation.

Parameters:
BLOCKSIZE, 4, words per burst; power of two, at least 2.
WAIT_CYCLES, 1, memory wait-cycle setting; sizes the post-reset drain.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_req  in  1  I-side burst request (read only); level, held until i_done
i_addr  in  32  I-side address; held stable while i_req is high
i_rd  out  32  read data for the current word (copy of mem_rd)
i_wordvalid  out  1  I-side word returned this cycle
i_done  out  1  I-side burst complete; coincides with the last i_wordvalid
d_req  in  1  D-side burst request; level, held until d_done
d_we  in  1  D-side burst is a write; held with d_req
d_addr  in  32  D-side address; held stable while d_req is high
d_wd  in  32  D-side write data for word index burst_word
d_rd  out  32  read data for the current word (copy of mem_rd)
d_wordvalid  out  1  D-side word accepted or returned this cycle
d_done  out  1  D-side burst complete
burst_word  out  log2(BLOCKSIZE)  current word index within the burst
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable
mem_a  out  32  memory byte address
mem_wd  out  32  memory write data
mem_rd  in  32  memory read data
mem_valid  in  1  memory word complete (one-cycle pulse)

Behaviour:
- States: DRAIN, IDLE, BUSY_I, BUSY_D. All registers update on posedge clk.
- Reset:
  - state forced to DRAIN; drain counter loaded to WAIT_CYCLES+3.
  - word counter cleared to 0; last-grant register set to I, so D wins the first tie.
  - All outputs are 0 while reset is high and in DRAIN/IDLE.
- DRAIN: counter decrements each cycle. At 0 the state moves to IDLE. mem_valid is ignored here, so stale completions from a burst aborted by reset are absorbed (the memory model has no reset).
- IDLE arbitration, decided on the current-cycle i_req/d_req:
  - only one requester → grant it;
  - both requesting → grant the one not equal to last-grant (round-robin);
  - the grant is registered: BUSY_x is entered at the next edge, with the word counter at 0 and last-grant updated.
  - mem_valid in IDLE is ignored.
- BUSY_x:
  - mem_a = {addr_x[31:log2(BLOCKSIZE)+2], word counter, 2'b00}. Bursts are block-aligned and low address bits are ignored.
  - mem_re = 1 for BUSY_I, or BUSY_D with d_we = 0. mem_we = d_we in BUSY_D.
  - mem_wd = d_wd. burst_word = word counter.
- Word completion: on mem_valid in BUSY_x:
  - x_wordvalid = 1 in the same cycle, with x_rd = mem_rd.
  - The counter increments at the edge, so the next word's address is presented during the memory's idle cycle.
- Burst completion: on mem_valid with counter = BLOCKSIZE-1:
  - x_done = 1 in the same cycle;
  - counter wraps to 0 and the state returns to IDLE.
  - There is a minimum of one IDLE cycle between bursts. A requester still asserting req in that IDLE cycle is a new request.
- Timing and ownership:
  - Per-word latency is whatever the memory gives. Burst latency = 1 grant cycle + BLOCKSIZE × (memory word time).
  - The non-owner's wordvalid/done are always 0. i_rd and d_rd may mirror mem_rd at all times; they are meaningful only with wordvalid.
- Requester drops req mid-burst: the burst still runs to completion. Bursts are not abortable except by reset.
- Reset mid-burst: abandon immediately, with no done pulse, and enter DRAIN.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {DRAIN, IDLE, BUSY_I, BUSY_D};
  - the requester enum {REQ_I, REQ_D};
  - a localparam function for the word-index width.
- Sub-module mem_arb_rr: the two-input round-robin picker (req pair plus last-grant in, grant out, combinational). The rest stays in mem_arbiter.

Test Plan:
- Reset with WAIT_CYCLES=1, then i_req=1 with i_addr=0x104 → no mem_re during the 4 drain cycles. Then mem_a steps 0x100, 0x104, 0x108, 0x10C; four i_wordvalid pulses; i_done with the 4th; d_* outputs stay 0.
- d_req=1, d_we=1, d_addr=0x2000, with d_wd driven as 0xA0+burst_word → mem_we held and mem_re=0. Memory words 0x2000..0x200C read back 0xA0..0xA3; d_done pulses once.
- i_req and d_req both rise in the same IDLE cycle after reset → D served first, then I. With both held continuously, grants alternate D, I, D, I, separated by exactly one IDLE cycle.
- Reset asserted after word 2 of a D read burst → outputs go to 0 immediately. The stale mem_valid arriving during DRAIN produces no d_wordvalid. The next d_req burst returns the correct 4 words.
- i_req dropped after the first word → the burst still completes 4 words plus i_done. The arbiter then stays in IDLE with mem_re=0.
- With BLOCKSIZE=8: d_addr=0x33C → mem_a covers 0x320..0x33C, and burst_word wraps 7→0 on d_done.
